// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_pkg.sv - shared types and limits for the registered N:1 mux
package gf180mcu_fd_sc_mcu9t5v0__muxn_pkg;

  // RUN passes data through; BLANK holds the output at zero while a select change settles
  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam int N_MIN   = 2;
  localparam int N_MAX   = 16;
  localparam int W_MIN   = 1;
  localparam int W_MAX   = 64;
  localparam int GAP_MIN = 0;
  localparam int GAP_MAX = 15;

  // Blanking counter width; wide enough for GAP_MAX
  localparam int CNT_W = 4;

  function automatic bit params_ok(input int n, input int w, input int gap);
    return (n >= N_MIN) && (n <= N_MAX) &&
           (w >= W_MIN) && (w <= W_MAX) &&
           (gap >= GAP_MIN) && (gap <= GAP_MAX);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_comb.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_comb.sv - combinational N:1 W-bit mux, zero for out-of-range select
module gf180mcu_fd_sc_mcu9t5v0__muxn_comb #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic [N*W-1:0] I,
  input  logic [SW-1:0]  SEL,
  output logic [W-1:0]   Y
);

  // Select channel SEL; any code with no matching channel yields zero
  always_comb begin
    Y = '0;
    for (int k = 0; k < N; k++) begin
      if (SEL == SW'(k)) begin
        Y = I[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_reg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_reg.sv - registered N:1 mux with handshaked, blanked select changes
module gf180mcu_fd_sc_mcu9t5v0__muxn_reg
  import gf180mcu_fd_sc_mcu9t5v0__muxn_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 1,
  parameter int GAP = 1,
  parameter int SW  = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [N*W-1:0]  I,
  input  logic [SW-1:0]   S_REQ,
  input  logic            S_VLD,
  output logic            S_RDY,
  output logic [SW-1:0]   S_CUR,
  output logic [W-1:0]    Z,
  output logic            ZV,
  output logic            ERR
);

  localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP);
  localparam logic [SW:0]      N_LIM   = (SW+1)'(N);
  localparam bit               NO_GAP  = (GAP == 0);

  generate
    if (!params_ok(N, W, GAP)) begin : g_bad_params
      $error("muxn_reg: parameter out of range (N=%0d W=%0d GAP=%0d)", N, W, GAP);
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    pend;
  logic             accept;
  logic             req_oor;
  logic             req_change;
  logic             bypass;
  logic [SW-1:0]    mux_sel;
  logic [W-1:0]     mux_y;

  assign S_RDY      = (state == RUN);
  assign accept     = S_VLD && S_RDY;
  assign req_oor    = ({1'b0, S_REQ} >= N_LIM);
  // Requests for the current channel or an invalid one leave the data path untouched
  assign req_change = accept && !req_oor && (S_REQ != S_CUR);
  // With no blanking the new channel is captured on the accepting edge itself
  assign bypass     = req_change && NO_GAP;
  assign mux_sel    = bypass ? S_REQ : S_CUR;

  gf180mcu_fd_sc_mcu9t5v0__muxn_comb #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_mux (
    .I   (I),
    .SEL (mux_sel),
    .Y   (mux_y)
  );

  // Next state: enter BLANK on a real channel change, leave when the counter expires
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (req_change && !NO_GAP) state_nxt = BLANK;
      BLANK:   if (cnt == CNT_W'(1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Data path: output capture, blanking counter, pending select and error pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      pend  <= '0;
      S_CUR <= '0;
      Z     <= '0;
      ZV    <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      ERR <= accept && req_oor;
      case (state)
        RUN: begin
          if (req_change && !NO_GAP) begin
            pend <= S_REQ;
            cnt  <= GAP_CNT;
            Z    <= '0;
            ZV   <= 1'b0;
          end else begin
            if (req_change) S_CUR <= S_REQ;
            if (EN) begin
              Z  <= mux_y;
              ZV <= 1'b1;
            end else if (req_change) begin
              // Z still holds the old channel's word, so it no longer matches S_CUR
              ZV <= 1'b0;
            end
          end
        end
        BLANK: begin
          cnt <= cnt - CNT_W'(1);
          Z   <= '0;
          ZV  <= 1'b0;
          if (cnt == CNT_W'(1)) S_CUR <= pend;
        end
        default: ;
      endcase
    end
  end

endmodule
